tx_buff_sched: RTL and testbench
================================

TX_BUFF_SCHED -- requirements
Module: tx_buff_sched

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3: reloads allowed after tx_err before abort (range 0..3).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 16: max cycles waiting for tx_buff_busy (range 1..255).
REQ-003 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have req  input  4  per-mailbox level transmit request.
REQ-006 SHALL have grant  output  4  one-hot owner of current transaction, 0 when idle.
REQ-007 SHALL have mb_rd_addr  output  4  byte index 0..9 into granted mailbox.
REQ-008 SHALL have mb_rd_data  input  8  byte from granted mailbox, combinational from mb_rd_addr.
REQ-009 SHALL have tx_buff_ld  output  1  one-cycle load pulse to transmit buffer.
REQ-010 SHALL have data_out  output  8  byte stream to buffer data input.
REQ-011 SHALL have tx_buff_busy  input  1  buffer reports 10-byte load complete.
REQ-012 SHALL have frame_start  output  1  one-cycle start pulse to frame generator.
REQ-013 SHALL have tx_done, tx_err  input  1 each  frame generator result pulses.
REQ-014 SHALL have ack, fail  output  4 each  one-cycle per-mailbox completion/abort pulses.
REQ-015 SHALL have sched_busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have retry_cnt  output  2  reloads used in current transaction.

Function
REQ-017 SHALL implement states IDLE, LOAD, STREAM, WAIT_BUF, START, WAIT_TX, DONE, FAIL.
REQ-018 IDLE: any req bit high -> registered grant to round-robin winner searching from rr_ptr upward with wrap 3->0; retry_cnt cleared; next LOAD.
REQ-019 LOAD: tx_buff_ld=1 for exactly this cycle; byte counter cleared; next STREAM.
REQ-020 STREAM: exactly 10 cycles, mb_rd_addr = counter 0..9, data_out = mb_rd_data combinationally; after counter 9 -> WAIT_BUF.
REQ-021 Outside STREAM: data_out = 8'h00, mb_rd_addr = 4'h0.
REQ-022 WAIT_BUF: tx_buff_busy high -> START; BUSY_TIMEOUT cycles elapsed without it -> FAIL; timeout counter cleared on entry.
REQ-023 START: frame_start=1 for this cycle only; next WAIT_TX.
REQ-024 WAIT_TX: tx_err -> LOAD with retry_cnt+1 if retry_cnt < MAX_RETRY, else FAIL; tx_done alone -> DONE; no timeout.
REQ-025 tx_err and tx_done same cycle SHALL be treated as tx_err.
REQ-026 DONE: ack bit of granted mailbox pulses one cycle; grant -> 0; rr_ptr = granted index+1 mod 4; next IDLE.
REQ-027 FAIL: fail bit of granted mailbox pulses one cycle; grant -> 0; rr_ptr advances as in DONE; next IDLE.
REQ-028 Deassertion of req by the granted mailbox mid-transaction SHALL be ignored; transaction runs to DONE/FAIL.
REQ-029 tx_buff_busy, tx_done, tx_err outside their wait states SHALL be ignored.
REQ-030 Minimum latency req->frame_start SHALL be 13 cycles with tx_buff_busy already high (IDLE, LOAD, 10xSTREAM, WAIT_BUF).
REQ-031 A new grant SHALL NOT issue until the cycle after DONE/FAIL (at least one IDLE cycle between transactions).

Reset
REQ-032 reset SHALL asynchronously force state IDLE, rr_ptr=0, all counters 0, and every output (grant, mb_rd_addr, tx_buff_ld, data_out, frame_start, ack, fail, sched_busy, retry_cnt) to 0.
REQ-033 Reset mid-transaction SHALL abort silently: no ack or fail pulse emitted.

Verification
REQ-034 req=4'b0100, busy high 2 cycles after STREAM, tx_done 5 cycles after frame_start -> grant=0100, ld pulse, 10 bytes on data_out matching mailbox bytes 0..9, one frame_start, ack=0100 one cycle, rr_ptr=3.
REQ-035 req=4'b1111 held for 4 transactions, all tx_done -> grant order 0001,0010,0100,1000 then wraps to 0001.
REQ-036 tx_err on every attempt, MAX_RETRY=3 -> 4 LOAD pulses, retry_cnt 0..3, then fail pulse on granted bit, no ack.
REQ-037 tx_buff_busy never asserted, BUSY_TIMEOUT=16 -> fail pulse 16 cycles after WAIT_BUF entry, frame_start never asserted.
REQ-038 tx_done and tx_err same cycle on first attempt -> treated as error: retry_cnt=1, second LOAD pulse, no ack.
REQ-039 reset asserted during STREAM byte 5 -> all outputs 0 immediately, no ack/fail; after release with req=0010 -> fresh grant 0010 and full 10-byte stream.

Source files
------------

// File: rtl/tx_buff_sched.sv
// tx_buff_sched: round-robin transmit scheduler for four mailboxes.
// A granted mailbox is read out byte by byte (10 bytes) into the transmit
// buffer. The scheduler then waits for the buffer to report load complete,
// starts the frame generator, and retries on error up to MAX_RETRY reloads.
// Each transaction ends with one ack or fail pulse to the owning mailbox.
//
// Ports:
//   clk, reset          clock (rising edge) / async active-high reset
//   req[3:0]            per-mailbox level transmit request
//   grant[3:0]          one-hot owner of current transaction, 0 when idle
//   mb_rd_addr[3:0]     byte index into granted mailbox (0 outside STREAM)
//   mb_rd_data[7:0]     byte from granted mailbox (combinational)
//   tx_buff_ld          one-cycle load pulse to transmit buffer
//   data_out[7:0]       byte stream to buffer (0 outside STREAM)
//   tx_buff_busy        buffer reports 10-byte load complete
//   frame_start         one-cycle start pulse to frame generator
//   tx_done, tx_err     frame generator result pulses
//   ack[3:0], fail[3:0] one-cycle per-mailbox completion / abort pulses
//   sched_busy          high whenever not idle
//   retry_cnt[1:0]      reloads used in current transaction
module tx_buff_sched #(
   parameter int MAX_RETRY    = 3,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [3:0] mb_rd_addr,
   input  logic [7:0] mb_rd_data,
   output logic       tx_buff_ld,
   output logic [7:0] data_out,
   input  logic       tx_buff_busy,
   output logic       frame_start,
   input  logic       tx_done,
   input  logic       tx_err,
   output logic [3:0] ack,
   output logic [3:0] fail,
   output logic       sched_busy,
   output logic [1:0] retry_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD, ST_STREAM, ST_WAIT_BUF,
      ST_START, ST_WAIT_TX, ST_DONE, ST_FAIL
   } state_t;

   localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);
   localparam logic [7:0] TO_LAST   = 8'(BUSY_TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [1:0] rr_ptr;
   logic [1:0] gidx;
   logic [3:0] bcnt;
   logic [7:0] tcnt;
   logic [1:0] win_idx;
   logic       win_found;
   logic       retry_ok;

   // Round-robin search starting at rr_ptr, wrapping 3 -> 0.
   always_comb begin
      win_found = 1'b0;
      win_idx   = rr_ptr;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!win_found && req[2'(rr_ptr + 2'(i))]) begin
            win_found = 1'b1;
            win_idx   = 2'(rr_ptr + 2'(i));
         end
      end
   end

   assign retry_ok = (retry_cnt < RETRY_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:     if (win_found) state_nxt = ST_LOAD;
         ST_LOAD:     state_nxt = ST_STREAM;
         ST_STREAM:   if (bcnt == 4'd9) state_nxt = ST_WAIT_BUF;
         ST_WAIT_BUF: begin
            if (tx_buff_busy)           state_nxt = ST_START;
            else if (tcnt == TO_LAST)   state_nxt = ST_FAIL;
         end
         ST_START:    state_nxt = ST_WAIT_TX;
         // tx_err wins over a simultaneous tx_done.
         ST_WAIT_TX: begin
            if (tx_err)       state_nxt = retry_ok ? ST_LOAD : ST_FAIL;
            else if (tx_done) state_nxt = ST_DONE;
         end
         ST_DONE, ST_FAIL: state_nxt = ST_IDLE;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant     <= '0;
         gidx      <= '0;
         rr_ptr    <= '0;
         bcnt      <= '0;
         tcnt      <= '0;
         retry_cnt <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (win_found) begin
                  grant     <= 4'b0001 << win_idx;
                  gidx      <= win_idx;
                  retry_cnt <= '0;
               end
            end
            ST_LOAD:   bcnt <= '0;
            ST_STREAM: begin
               bcnt <= bcnt + 4'd1;
               tcnt <= '0;
            end
            ST_WAIT_BUF: tcnt <= tcnt + 8'd1;
            ST_WAIT_TX: begin
               if (tx_err && retry_ok) retry_cnt <= retry_cnt + 2'd1;
            end
            ST_DONE, ST_FAIL: begin
               grant  <= '0;
               rr_ptr <= gidx + 2'd1;
            end
            default: ;
         endcase
      end
   end

   // grant still holds the owner during DONE/FAIL, so it selects the pulse bit.
   assign tx_buff_ld  = (state == ST_LOAD);
   assign frame_start = (state == ST_START);
   assign sched_busy  = (state != ST_IDLE);
   assign ack         = (state == ST_DONE) ? grant : '0;
   assign fail        = (state == ST_FAIL) ? grant : '0;
   assign mb_rd_addr  = (state == ST_STREAM) ? bcnt : '0;
   assign data_out    = (state == ST_STREAM) ? mb_rd_data : '0;

endmodule

// File: tb/tb_tx_buff_sched.sv
// tb_tx_buff_sched: directed bench for tx_buff_sched with a behavioural
// mailbox model and a byte scoreboard for the streamed data.
module tb_tx_buff_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] grant;
   logic [3:0] mb_rd_addr;
   logic [7:0] mb_rd_data;
   logic       tx_buff_ld;
   logic [7:0] data_out;
   logic       tx_buff_busy;
   logic       frame_start;
   logic       tx_done;
   logic       tx_err;
   logic [3:0] ack;
   logic [3:0] fail;
   logic       sched_busy;
   logic [1:0] retry_cnt;

   int checks   = 0;
   int failures = 0;
   logic [7:0] sb[$];

   tx_buff_sched #(.MAX_RETRY(3), .BUSY_TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .req(req), .grant(grant),
      .mb_rd_addr(mb_rd_addr), .mb_rd_data(mb_rd_data),
      .tx_buff_ld(tx_buff_ld), .data_out(data_out),
      .tx_buff_busy(tx_buff_busy), .frame_start(frame_start),
      .tx_done(tx_done), .tx_err(tx_err), .ack(ack), .fail(fail),
      .sched_busy(sched_busy), .retry_cnt(retry_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mb_byte(input int mb, input int a);
      return 8'(mb * 37 + a * 11 + 90);
   endfunction

   // Mailbox memories: byte selected by the current grant and read address.
   always_comb begin
      mb_rd_data = 8'h00;
      for (int i = 0; i < 4; i++)
         if (grant[i]) mb_rd_data = mb_byte(i, int'(mb_rd_addr));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input int mb);
      for (int k = 0; k < 10; k++) sb.push_back(mb_byte(mb, k));
   endtask

   task automatic stream(input string tag, input int n);
      logic [7:0] e;
      for (int k = 0; k < n; k++) begin
         step();
         if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
         end else begin
            e = sb.pop_front();
            chk({tag, "_data"}, data_out, e);
            chk({tag, "_addr"}, mb_rd_addr, k);
         end
      end
   endtask

   task automatic wait_ld(input string tag);
      int n = 0;
      while (tx_buff_ld !== 1'b1 && n < 40) begin step(); n++; end
      chk({tag, "_ld"}, tx_buff_ld, 1);
   endtask

   task automatic wait_fs(input string tag);
      int n = 0;
      while (frame_start !== 1'b1 && n < 40) begin step(); n++; end
      chk({tag, "_frame_start"}, frame_start, 1);
   endtask

   task automatic finish_ok(input string tag, input logic [3:0] exp_g);
      step();
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk({tag, "_ack"}, ack, exp_g);
      chk({tag, "_nofail"}, fail, 0);
      step();
      chk({tag, "_idle_grant"}, grant, 0);
      chk({tag, "_idle_busy"}, sched_busy, 0);
   endtask

   task automatic outs_zero(input string tag);
      chk(tag, {grant, mb_rd_addr, tx_buff_ld, data_out, frame_start,
                ack, fail, sched_busy, retry_cnt}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; req = '0; tx_buff_busy = 1'b0; tx_done = 1'b0; tx_err = 1'b0;
      step();
      step();
      outs_zero("reset_outs");
      reset = 1'b0;
      step();
      outs_zero("idle_outs");

      // Single transaction, mailbox 2, busy two cycles after stream.
      req = 4'b0100;
      push_frame(2);
      wait_ld("t1");
      chk("t1_grant", grant, 4'b0100);
      req = '0;
      stream("t1", 10);
      step();
      chk("t1_wb_fs", frame_start, 0);
      chk("t1_wb_data", {data_out, mb_rd_addr}, 0);
      step();
      tx_buff_busy = 1'b1;
      step();
      chk("t1_fs", frame_start, 1);
      tx_buff_busy = 1'b0;
      step();
      chk("t1_fs_once", frame_start, 0);
      for (int i = 0; i < 4; i++) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("t1_ack", ack, 4'b0100);
      step();
      chk("t1_ack_once", ack, 0);
      chk("t1_grant_clr", grant, 0);
      chk("t1_rr_ptr", dut.rr_ptr, 3);

      // Round robin with all requests held.
      reset = 1'b1;
      step();
      reset = 1'b0;
      tx_buff_busy = 1'b1;
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         push_frame(t % 4);
         wait_ld("rr");
         chk("rr_grant", grant, 4'b0001 << (t % 4));
         stream("rr", 10);
         wait_fs("rr");
         finish_ok("rr", 4'b0001 << (t % 4));
      end
      req = '0;
      step();

      // Error on every attempt: four loads then fail.
      req = 4'b0001;
      for (int a = 0; a < 4; a++) begin
         push_frame(0);
         wait_ld("retry");
         chk("retry_cnt", retry_cnt, a);
         chk("retry_grant", grant, 4'b0001);
         req = '0;
         stream("retry", 10);
         wait_fs("retry");
         step();
         tx_err = 1'b1;
         step();
         tx_err = 1'b0;
      end
      chk("retry_fail", fail, 4'b0001);
      chk("retry_noack", ack, 0);
      step();
      chk("retry_fail_once", fail, 0);

      // Buffer never reports busy: timeout, stray result pulses ignored.
      tx_buff_busy = 1'b0;
      req = 4'b0010;
      push_frame(1);
      wait_ld("to");
      chk("to_grant", grant, 4'b0010);
      req = '0;
      stream("to", 10);
      for (int k = 1; k <= 16; k++) begin
         step();
         tx_done = (k == 3);
         tx_err  = (k == 5);
         chk("to_wait", {fail, ack, frame_start}, 0);
      end
      tx_done = 1'b0;
      tx_err  = 1'b0;
      step();
      chk("to_fail", fail, 4'b0010);
      step();

      // Simultaneous done/err counts as error.
      tx_buff_busy = 1'b1;
      req = 4'b0100;
      push_frame(2);
      wait_ld("both");
      chk("both_grant", grant, 4'b0100);
      req = '0;
      stream("both", 10);
      wait_fs("both");
      step();
      tx_done = 1'b1;
      tx_err  = 1'b1;
      step();
      tx_done = 1'b0;
      tx_err  = 1'b0;
      chk("both_reload", tx_buff_ld, 1);
      chk("both_retry", retry_cnt, 1);
      chk("both_noack", ack, 0);
      push_frame(2);
      stream("both2", 10);
      wait_fs("both2");
      finish_ok("both2", 4'b0100);

      // Reset during byte 5 of the stream.
      req = 4'b0001;
      push_frame(0);
      wait_ld("rst");
      chk("rst_grant", grant, 4'b0001);
      req = '0;
      stream("rst", 5);
      step();
      chk("rst_byte5", mb_rd_addr, 5);
      reset = 1'b1;
      #1;
      outs_zero("rst_async");
      sb.delete();
      step();
      chk("rst_quiet", {ack, fail}, 0);
      reset = 1'b0;
      step();
      chk("rst_quiet2", {ack, fail}, 0);
      req = 4'b0010;
      push_frame(1);
      wait_ld("post");
      chk("post_grant", grant, 4'b0010);
      req = '0;
      stream("post", 10);
      wait_fs("post");
      finish_ok("post", 4'b0010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
